// File: rtl/fwd_hazard_ctrl.sv
// Forwarding control words and load-use stall for the ID/EX boundary.
// Define FWD_HAZARD_FORWARD_EN to enable forwarding; otherwise every dependency stalls.
module fwd_hazard_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       idValid,
  input  logic [2:0] idRs,
  input  logic [2:0] idRt,
  input  logic       idRsUsed,
  input  logic       idRtUsed,
  input  logic       idRegWrite,
  input  logic [2:0] idRd,
  input  logic [1:0] idWbSel,
  input  logic       flush,
  output logic [3:0] fwCntrlA,
  output logic [3:0] fwCntrlB,
  output logic       stall
);

  localparam logic [1:0] WbMem = 2'b01;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic [2:0] rd;
    logic [1:0] wb_sel;
  } slot_t;

  slot_t      x_q, x_d, m_q;
  logic [3:0] fw_a_q, fw_a_d;
  logic [3:0] fw_b_q, fw_b_d;

  logic hit_x_a, hit_x_b, hit_m_a, hit_m_b;

  assign hit_x_a = x_q.valid & x_q.reg_write & idRsUsed & (x_q.rd == idRs);
  assign hit_x_b = x_q.valid & x_q.reg_write & idRtUsed & (x_q.rd == idRt);
  assign hit_m_a = m_q.valid & m_q.reg_write & idRsUsed & (m_q.rd == idRs);
  assign hit_m_b = m_q.valid & m_q.reg_write & idRtUsed & (m_q.rd == idRt);

`ifdef FWD_HAZARD_FORWARD_EN
  logic [3:0] word_a, word_b;

  // The EX producer is the youngest and wins; a load in EX cannot be forwarded yet.
  always_comb begin
    word_a = 4'b0000;
    if (hit_x_a && (x_q.wb_sel != WbMem)) begin
      word_a = {2'b10, x_q.wb_sel};
    end else if (hit_m_a) begin
      word_a = {2'b11, m_q.wb_sel};
    end
    word_b = 4'b0000;
    if (hit_x_b && (x_q.wb_sel != WbMem)) begin
      word_b = {2'b10, x_q.wb_sel};
    end else if (hit_m_b) begin
      word_b = {2'b11, m_q.wb_sel};
    end
  end

  assign stall = idValid & ~flush & ((hit_x_a | hit_x_b) & (x_q.wb_sel == WbMem));
`else
  logic [3:0] word_a, word_b;
  logic       unused_wb_sel;

  assign word_a        = 4'b0000;
  assign word_b        = 4'b0000;
  assign unused_wb_sel = ^{x_q.wb_sel, m_q.wb_sel};
  assign stall         = idValid & ~flush & (hit_x_a | hit_x_b | hit_m_a | hit_m_b);
`endif

  always_comb begin
    x_d.valid     = idValid;
    x_d.reg_write = idRegWrite;
    x_d.rd        = idRd;
    x_d.wb_sel    = idWbSel;
    fw_a_d        = word_a;
    fw_b_d        = word_b;
    // Stall and flush both inject a bubble into EX.
    if (stall || flush) begin
      x_d.valid = 1'b0;
      fw_a_d    = 4'b0000;
      fw_b_d    = 4'b0000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      m_q    <= '0;
      fw_a_q <= 4'b0000;
      fw_b_q <= 4'b0000;
    end else begin
      x_q    <= x_d;
      m_q    <= x_q;
      fw_a_q <= fw_a_d;
      fw_b_q <= fw_b_d;
    end
  end

  assign fwCntrlA = fw_a_q;
  assign fwCntrlB = fw_b_q;

endmodule
